step_seq: RTL and testbench
===========================

STEP_SEQ -- requirements
Module: step_seq

Interface
REQ-001: Parameter NUM_STEPS, default 4, is the number of one-hot step outputs; legal range 2..16.
REQ-002: Parameter IDX_W, default 2, is the step index width; the SHALL constraint is 2^IDX_W >= NUM_STEPS.
REQ-003: Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004: Port rst_n  input  1  is the reset, asynchronous and active-low.
REQ-005: Port en  input  1  is the run enable: 1 requests sequencing, 0 requests a graceful stop.
REQ-006: Port restart  input  1  is a synchronous request to return to step 0.
REQ-007: Port stall  input  1  holds the current step while high.
REQ-008: Port single  input  1  selects single-step mode.
REQ-009: Port step_req  input  1  is the advance pulse used only in single-step mode.
REQ-010: Port last_step  input  IDX_W  is the runtime index of the final step in a cycle.
REQ-011: Port step  output  NUM_STEPS  is the registered one-hot step vector.
REQ-012: Port step_idx  output  IDX_W  is the registered binary index of the active step.
REQ-013: Port cycle_done  output  1  is a one-cycle pulse on wrap from the final step to step 0.
REQ-014: Port busy  output  1  is high while the block is in state ACTIVE.

Function
REQ-015: The block SHALL implement two states, IDLE and ACTIVE.
REQ-016: In IDLE: step=0, step_idx=0, busy=0.
REQ-017: IDLE->ACTIVE on an edge with en=1: step_idx<=0, step<=1 (bit 0), busy<=1, and the limit register lim<=clamp(last_step).
REQ-018: clamp(x) SHALL equal x if x<=NUM_STEPS-1, else NUM_STEPS-1.
REQ-019: In ACTIVE, step SHALL always equal one-hot(step_idx), with exactly one bit set.
REQ-020: Advance condition: adv = !stall && (!single || step_req).
REQ-021: In ACTIVE with adv=1 and step_idx<lim: step_idx<=step_idx+1.
REQ-022: In ACTIVE with adv=1 and step_idx==lim (wrap) and en=1: step_idx<=0, cycle_done<=1, lim<=clamp(last_step).
REQ-023: In ACTIVE with adv=1 and step_idx==lim and en=0: state<=IDLE, step<=0, step_idx<=0, cycle_done<=1.
REQ-024: en=0 SHALL NOT shorten a cycle in progress: the sequence completes through lim before the block goes IDLE.
REQ-025: With adv=0, step, step_idx and lim SHALL hold.
REQ-026: cycle_done SHALL be 0 on every edge without a wrap, so it never lasts more than one cycle.
REQ-027: last_step SHALL be sampled only on entry, on wrap and on restart; changes mid-cycle have no effect until the next sample.
REQ-028: restart in ACTIVE with en=1: step_idx<=0, step<=1, lim<=clamp(last_step), cycle_done<=0; it overrides stall and adv.
REQ-029: restart in ACTIVE with en=0: immediate IDLE, with outputs as in REQ-016 and cycle_done=0.
REQ-030: restart in IDLE SHALL be ignored; entry follows REQ-017.
REQ-031: step_req in single=0 mode SHALL be ignored; stall SHALL take priority over step_req.
REQ-032: The index SHALL never exceed lim; lim=0 SHALL give step[0] high continuously with cycle_done=1 on every advancing edge.

Reset
REQ-033: While rst_n=0, independent of clk: state=IDLE, step=0, step_idx=0, cycle_done=0, busy=0, lim=NUM_STEPS-1.
REQ-034: Reset asserted mid-operation SHALL abort immediately; after release the block re-enters only via REQ-017.

Verification
REQ-035: NUM_STEPS=4, last_step=3, en=1 held -> step 0001,0010,0100,1000 repeating; cycle_done high with each 0001 after the first; busy=1.
REQ-036: NUM_STEPS=8, last_step=2 -> indices 0,1,2,0; last_step=9 with NUM_STEPS=8 -> wraps after index 7.
REQ-037: stall high for 3 cycles at index 1 -> step=0010 held 4 cycles, then 0100; no cycle_done.
REQ-038: single=1, step_req pulses 5 cycles apart -> index advances once per pulse; no advance between pulses.
REQ-039: en dropped at index 1 (lim=3) -> indices 2,3 complete, cycle_done pulse, then step=0, busy=0; restart with en=1 at index 2 -> next step=0001 with no cycle_done.
REQ-040: rst_n low asynchronously at index 2 -> all outputs 0 before the next edge; restart in IDLE with en=0 -> no change.

Source files
------------

// File: rtl/step_seq.sv
// One-hot step sequencer: walks step 0..lim under run/stall/single-step control,
// pulsing cycle_done on each wrap and stopping gracefully only at the end of a cycle.
//
// state  | meaning
// IDLE   | outputs cleared, waiting for en to start a cycle at step 0
// ACTIVE | sequencing; step is one-hot of step_idx, lim bounds the cycle
module step_seq #(
    parameter int NUM_STEPS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 restart,
    input  logic                 stall,
    input  logic                 single,
    input  logic                 step_req,
    input  logic [IDX_W-1:0]     last_step,
    output logic [NUM_STEPS-1:0] step,
    output logic [IDX_W-1:0]     step_idx,
    output logic                 cycle_done,
    output logic                 busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_STEPS - 1);

    state_t           state;
    logic [IDX_W-1:0] lim;
    logic             adv;

    function automatic logic [IDX_W-1:0] clamp(input logic [IDX_W-1:0] x);
        return (x > MAX_IDX) ? MAX_IDX : x;
    endfunction

    function automatic logic [NUM_STEPS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_STEPS-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_STEPS; k++) begin
            r[k] = (idx == IDX_W'(k));
        end
        return r;
    endfunction

    assign adv = !stall && (!single || step_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step       <= '0;
            step_idx   <= '0;
            cycle_done <= 1'b0;
            busy       <= 1'b0;
            lim        <= MAX_IDX;
        end else begin
            cycle_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state    <= ACTIVE;
                        step_idx <= '0;
                        step     <= onehot('0);
                        busy     <= 1'b1;
                        lim      <= clamp(last_step);
                    end
                end
                ACTIVE: begin
                    // restart wins over stall and advance; with en low it aborts outright
                    if (restart) begin
                        step_idx <= '0;
                        if (en) begin
                            step <= onehot('0);
                            lim  <= clamp(last_step);
                        end else begin
                            state <= IDLE;
                            step  <= '0;
                            busy  <= 1'b0;
                        end
                    end else if (adv) begin
                        if (step_idx < lim) begin
                            step_idx <= step_idx + IDX_W'(1);
                            step     <= onehot(step_idx + IDX_W'(1));
                        end else begin
                            cycle_done <= 1'b1;
                            step_idx   <= '0;
                            if (en) begin
                                step <= onehot('0);
                                lim  <= clamp(last_step);
                            end else begin
                                state <= IDLE;
                                step  <= '0;
                                busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    step  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_seq.sv
// Directed bench for step_seq: a 4-step instance for control behaviour and an
// 8-step instance for runtime limit and clamping.
module tb_step_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, restart, stall, single, step_req;
    logic [1:0] last_step;
    logic [3:0] step_a;
    logic [1:0] idx_a;
    logic       cd_a, busy_a;

    logic       en8;
    logic [3:0] last8;
    logic [7:0] step_b;
    logic [3:0] idx_b;
    logic       cd_b, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    step_seq #(.NUM_STEPS(4), .IDX_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .restart(restart), .stall(stall),
        .single(single), .step_req(step_req), .last_step(last_step),
        .step(step_a), .step_idx(idx_a), .cycle_done(cd_a), .busy(busy_a)
    );

    step_seq #(.NUM_STEPS(8), .IDX_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en8), .restart(restart), .stall(stall),
        .single(single), .step_req(step_req), .last_step(last8),
        .step(step_b), .step_idx(idx_b), .cycle_done(cd_b), .busy(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // observed/expected packed as {busy, cycle_done, step_idx, step}
    task automatic chk_a(input string tag, input logic [3:0] es, input logic [1:0] ei,
                         input logic ec, input logic eb);
        logic [7:0] o, e;
        o = {busy_a, cd_a, idx_a, step_a};
        e = {eb, ec, ei, es};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b_%b_%0d_%b expected=%b_%b_%0d_%b", tag,
                   busy_a, cd_a, idx_a, step_a, eb, ec, ei, es);
        end
    endtask

    task automatic chk_b(input string tag, input logic [7:0] es, input logic [3:0] ei,
                         input logic ec);
        logic [12:0] o, e;
        o = {cd_b, idx_b, step_b};
        e = {ec, ei, es};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b_%0d_%b expected=%b_%0d_%b", tag,
                   cd_b, idx_b, step_b, ec, ei, es);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; restart = 1'b0; stall = 1'b0; single = 1'b0;
        step_req = 1'b0; last_step = 2'd3; en8 = 1'b0; last8 = 4'd2;
        #3;
        chk_a("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_a("idle_en0", 4'b0000, 2'd0, 1'b0, 1'b0);
        restart = 1'b1;
        tick();
        chk_a("restart_in_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        restart = 1'b0;

        // free run with lim=3
        en = 1'b1;
        tick(); chk_a("entry", 4'b0001, 2'd0, 1'b0, 1'b1);
        tick(); chk_a("run1", 4'b0010, 2'd1, 1'b0, 1'b1);
        tick(); chk_a("run2", 4'b0100, 2'd2, 1'b0, 1'b1);
        tick(); chk_a("run3", 4'b1000, 2'd3, 1'b0, 1'b1);
        tick(); chk_a("wrap1", 4'b0001, 2'd0, 1'b1, 1'b1);
        tick(); chk_a("run1b", 4'b0010, 2'd1, 1'b0, 1'b1);

        // stall 3 cycles at index 1
        stall = 1'b1;
        tick(); chk_a("stall1", 4'b0010, 2'd1, 1'b0, 1'b1);
        tick(); chk_a("stall2", 4'b0010, 2'd1, 1'b0, 1'b1);
        tick(); chk_a("stall3", 4'b0010, 2'd1, 1'b0, 1'b1);
        stall = 1'b0;
        tick(); chk_a("post_stall", 4'b0100, 2'd2, 1'b0, 1'b1);
        tick(); chk_a("post_stall3", 4'b1000, 2'd3, 1'b0, 1'b1);
        tick(); chk_a("wrap2", 4'b0001, 2'd0, 1'b1, 1'b1);

        // mid-cycle last_step change takes effect only at the wrap
        last_step = 2'd1;
        tick(); chk_a("mid_ls1", 4'b0010, 2'd1, 1'b0, 1'b1);
        tick(); chk_a("mid_ls2", 4'b0100, 2'd2, 1'b0, 1'b1);
        tick(); chk_a("mid_ls3", 4'b1000, 2'd3, 1'b0, 1'b1);
        tick(); chk_a("wrap_lim1", 4'b0001, 2'd0, 1'b1, 1'b1);
        tick(); chk_a("lim1_idx1", 4'b0010, 2'd1, 1'b0, 1'b1);
        last_step = 2'd3;
        tick(); chk_a("lim1_wrap", 4'b0001, 2'd0, 1'b1, 1'b1);

        // single-step mode
        single = 1'b1;
        tick(); chk_a("single_hold", 4'b0001, 2'd0, 1'b0, 1'b1);
        step_req = 1'b1;
        tick(); chk_a("single_pulse1", 4'b0010, 2'd1, 1'b0, 1'b1);
        step_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); chk_a("single_gap", 4'b0010, 2'd1, 1'b0, 1'b1);
        end
        step_req = 1'b1; stall = 1'b1;
        tick(); chk_a("stall_over_req", 4'b0010, 2'd1, 1'b0, 1'b1);
        stall = 1'b0;
        tick(); chk_a("single_pulse2", 4'b0100, 2'd2, 1'b0, 1'b1);
        step_req = 1'b0; single = 1'b0;

        // graceful stop: en dropped at index 1
        tick(); chk_a("pre_stop3", 4'b1000, 2'd3, 1'b0, 1'b1);
        tick(); chk_a("pre_stop_wrap", 4'b0001, 2'd0, 1'b1, 1'b1);
        tick(); chk_a("pre_stop1", 4'b0010, 2'd1, 1'b0, 1'b1);
        en = 1'b0;
        tick(); chk_a("stop_run2", 4'b0100, 2'd2, 1'b0, 1'b1);
        tick(); chk_a("stop_run3", 4'b1000, 2'd3, 1'b0, 1'b1);
        tick(); chk_a("stop_idle", 4'b0000, 2'd0, 1'b1, 1'b0);
        tick(); chk_a("stop_stays", 4'b0000, 2'd0, 1'b0, 1'b0);

        // restart with en=1 at index 2, then restart overriding a wrap
        en = 1'b1;
        tick(); chk_a("reentry", 4'b0001, 2'd0, 1'b0, 1'b1);
        tick(); tick(); chk_a("rs_idx2", 4'b0100, 2'd2, 1'b0, 1'b1);
        restart = 1'b1;
        tick(); chk_a("restart_en1", 4'b0001, 2'd0, 1'b0, 1'b1);
        restart = 1'b0;
        tick(); tick(); tick(); chk_a("rs_idx3", 4'b1000, 2'd3, 1'b0, 1'b1);
        restart = 1'b1;
        tick(); chk_a("restart_at_wrap", 4'b0001, 2'd0, 1'b0, 1'b1);
        restart = 1'b0;

        // restart with en=0 aborts immediately
        tick(); chk_a("pre_abort", 4'b0010, 2'd1, 1'b0, 1'b1);
        en = 1'b0; restart = 1'b1;
        tick(); chk_a("restart_en0", 4'b0000, 2'd0, 1'b0, 1'b0);
        restart = 1'b0;

        // lim = 0: step[0] held with cycle_done on every advancing edge
        last_step = 2'd0; en = 1'b1;
        tick(); chk_a("lim0_entry", 4'b0001, 2'd0, 1'b0, 1'b1);
        tick(); chk_a("lim0_wrap1", 4'b0001, 2'd0, 1'b1, 1'b1);
        tick(); chk_a("lim0_wrap2", 4'b0001, 2'd0, 1'b1, 1'b1);
        stall = 1'b1;
        tick(); chk_a("lim0_stall", 4'b0001, 2'd0, 1'b0, 1'b1);
        stall = 1'b0; last_step = 2'd3;
        tick(); chk_a("lim0_resample", 4'b0001, 2'd0, 1'b1, 1'b1);
        tick(); tick(); chk_a("pre_reset", 4'b0100, 2'd2, 1'b0, 1'b1);

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1 chk_a("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        en = 1'b0;
        #1 rst_n = 1'b1;
        tick(); chk_a("post_reset_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        en = 1'b1;
        tick(); chk_a("post_reset_entry", 4'b0001, 2'd0, 1'b0, 1'b1);
        en = 1'b0;

        // 8-step instance: lim=2, then last_step=9 clamps to 7
        last8 = 4'd2; en8 = 1'b1;
        tick(); chk_b("b_entry", 8'h01, 4'd0, 1'b0);
        tick(); chk_b("b_idx1", 8'h02, 4'd1, 1'b0);
        tick(); chk_b("b_idx2", 8'h04, 4'd2, 1'b0);
        last8 = 4'd9;
        tick(); chk_b("b_wrap_lim2", 8'h01, 4'd0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            tick(); chk_b("b_clamp_run", 8'(1 << i), 4'(i), 1'b0);
        end
        tick(); chk_b("b_wrap_lim7", 8'h01, 4'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
